ctrl_wbit_seq: RTL and testbench

Runtime-configurable weight-bit sequencer for the SMAC control path. It replaces the fixed-precision weight-bit counter with one whose weight precision and words-per-tile are programmed per tile through a valid/ready config handshake. It steps through bit positions on each weight-sample strobe and emits first, pre-last and last bit flags for the datapath FSM, plus a tile-completion pulse.

---
 rtl/smac_ctrl_pkg.sv | 27 ++
 rtl/ctrl_bit_cnt.sv | 43 ++++
 rtl/ctrl_wbit_seq.sv | 142 ++++++++++++++
 tb/tb_ctrl_wbit_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smac_ctrl_pkg.sv
// Shared types and helpers for the SMAC control path.
package smac_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned PW_MAX_DEF = 8;
   localparam int unsigned NW_MAX_DEF = 256;

   localparam int unsigned PREC_W_DEF = $clog2(PW_MAX_DEF + 1);
   localparam int unsigned NWRD_W_DEF = $clog2(NW_MAX_DEF + 1);

   // Width of a 0-based index over n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A tile config is usable only when both fields are within 1..max.
   function automatic logic cfg_legal(input int unsigned prec, input int unsigned nwords,
                                      input int unsigned pw_max, input int unsigned nw_max);
      return (prec >= 1) && (prec <= pw_max) && (nwords >= 1) && (nwords <= nw_max);
   endfunction

endpackage

// File: rtl/ctrl_bit_cnt.sv
// Wrapping 1..N counter: 0 after clear, first enable gives 1, enable at N wraps to 1.
module ctrl_bit_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max_val,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt,
   output logic         wrap
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Count sits at N: the next enable wraps back to 1.
   assign wrap = (cnt_q == max_val);

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? W'(1) : cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign cnt_nxt = cnt_d;

endmodule

// File: rtl/ctrl_wbit_seq.sv
// Runtime-configurable weight-bit sequencer: steps bit positions per weight strobe and
// flags first / pre-last / last bits plus a tile-completion pulse.
module ctrl_wbit_seq
   import smac_ctrl_pkg::*;
#(
   parameter int unsigned PW_MAX = PW_MAX_DEF,
   parameter int unsigned NW_MAX = NW_MAX_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [$clog2(PW_MAX+1)-1:0]   cfg_prec,
   input  logic [$clog2(NW_MAX+1)-1:0]   cfg_nwords,
   output logic                          cfg_err,
   input  logic                          w_cnt,
   input  logic                          cnt_clear,
   output logic [$clog2(PW_MAX+1)-1:0]   bit_idx,
   output logic [idx_w(NW_MAX)-1:0]      word_idx,
   output logic                          bit_first,
   output logic                          bit_pre,
   output logic                          bit_last,
   output logic                          busy,
   output logic                          tile_done
);

   localparam int unsigned PREC_W = $clog2(PW_MAX + 1);
   localparam int unsigned NWRD_W = $clog2(NW_MAX + 1);
   localparam int unsigned WIDX_W = idx_w(NW_MAX);

   state_e              state_q, state_d;
   logic [PREC_W-1:0]   prec_q, prec_d;
   logic [NWRD_W-1:0]   nwords_q, nwords_d;
   logic                accept, err_d, run, run_end;
   logic [PREC_W-1:0]   bit_q, bit_d;
   logic                bit_at_max;
   logic [NWRD_W-1:0]   wc_q, wc_d;
   logic                wc_at_max;
   logic                bit_en, bit_clr, wc_en, wc_clr;
   logic                first_d, pre_d, last_d;
   logic [WIDX_W-1:0]   widx_d;

   assign run = (state_q == StRun);
   // Last bit of last word is shown for one cycle, then the tile ends on its own.
   assign run_end = run && bit_at_max && wc_at_max;

   assign bit_en  = run && w_cnt && !run_end;
   assign bit_clr = cnt_clear || accept || run_end;
   // Word count is 1-based: bumped on the very first strobe and on each bit wrap.
   assign wc_en   = bit_en && ((bit_q == '0) || bit_at_max);
   assign wc_clr  = cnt_clear || accept;

   ctrl_bit_cnt #(.W(PREC_W)) u_bit_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bit_clr),
      .en      (bit_en),
      .max_val (prec_q),
      .cnt     (bit_q),
      .cnt_nxt (bit_d),
      .wrap    (bit_at_max)
   );

   ctrl_bit_cnt #(.W(NWRD_W)) u_word_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wc_clr),
      .en      (wc_en),
      .max_val (nwords_q),
      .cnt     (wc_q),
      .cnt_nxt (wc_d),
      .wrap    (wc_at_max)
   );

   // FSM next state and config latch; cnt_clear overrides everything.
   always_comb begin
      state_d  = state_q;
      prec_d   = prec_q;
      nwords_d = nwords_q;
      accept   = 1'b0;
      err_d    = 1'b0;
      if (cnt_clear) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_valid) begin
                  if (cfg_legal(32'(cfg_prec), 32'(cfg_nwords), PW_MAX, NW_MAX)) begin
                     accept   = 1'b1;
                     prec_d   = cfg_prec;
                     nwords_d = cfg_nwords;
                     state_d  = StRun;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StRun:   if (run_end) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Flags and word index decoded from next-state values so they line up with bit_idx.
   always_comb begin
      first_d = (state_d == StRun) && (bit_d == PREC_W'(1));
      pre_d   = (state_d == StRun) && (prec_d >= PREC_W'(2)) && (bit_d == prec_d - PREC_W'(1));
      last_d  = (state_d == StRun) && (bit_d != '0) && (bit_d == prec_d);
      widx_d  = '0;
      if (wc_d != '0) widx_d = WIDX_W'(wc_d - NWRD_W'(1));
   end

   // State, config and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         prec_q    <= '0;
         nwords_q  <= '0;
         cfg_err   <= 1'b0;
         bit_first <= 1'b0;
         bit_pre   <= 1'b0;
         bit_last  <= 1'b0;
         word_idx  <= '0;
      end else begin
         state_q   <= state_d;
         prec_q    <= prec_d;
         nwords_q  <= nwords_d;
         cfg_err   <= err_d;
         bit_first <= first_d;
         bit_pre   <= pre_d;
         bit_last  <= last_d;
         word_idx  <= widx_d;
      end
   end

   assign bit_idx   = bit_q;
   assign busy      = (state_q == StRun);
   assign cfg_ready = (state_q == StIdle);
   assign tile_done = (state_q == StDone);

endmodule

// File: tb/tb_ctrl_wbit_seq.sv
// Directed self-checking bench for ctrl_wbit_seq.
module tb_ctrl_wbit_seq;

   logic       clk, rst_n;
   logic       cfg_valid, cfg_ready, cfg_err;
   logic [3:0] cfg_prec;
   logic [8:0] cfg_nwords;
   logic       w_cnt, cnt_clear;
   logic [3:0] bit_idx;
   logic [7:0] word_idx;
   logic       bit_first, bit_pre, bit_last, busy, tile_done;

   int checks = 0;
   int failures = 0;

   ctrl_wbit_seq #(.PW_MAX(8), .NW_MAX(256)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_prec   (cfg_prec),
      .cfg_nwords (cfg_nwords),
      .cfg_err    (cfg_err),
      .w_cnt      (w_cnt),
      .cnt_clear  (cnt_clear),
      .bit_idx    (bit_idx),
      .word_idx   (word_idx),
      .bit_first  (bit_first),
      .bit_pre    (bit_pre),
      .bit_last   (bit_last),
      .busy       (busy),
      .tile_done  (tile_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [3:0] p, input logic [8:0] n);
      cfg_valid  = 1'b1;
      cfg_prec   = p;
      cfg_nwords = n;
      tick();
      cfg_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({cfg_ready, busy, tile_done, cfg_err, bit_first, bit_pre, bit_last} !== 7'b1000000 ||
          bit_idx !== 4'd0 || word_idx !== 8'd0) begin
         failures++;
         $display("FAIL reset: rdy=%b busy=%b done=%b err=%b bit=%0d word=%0d, want rdy=1 rest 0",
                  cfg_ready, busy, tile_done, cfg_err, bit_idx, word_idx);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_prec4();
      logic [3:0] eb;
      logic [7:0] ew;
      do_cfg(4'd4, 9'd2);
      checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0 || bit_idx !== 4'd0) begin
         failures++;
         $display("FAIL p4_cfg: busy=%b rdy=%b bit=%0d, want 1 0 0", busy, cfg_ready, bit_idx);
      end
      w_cnt = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            tick();
            w_cnt = 1'b0;
         end else begin
            tick();
         end
         eb = 4'(i % 4 + 1);
         ew = 8'(i / 4);
         checks++;
         if (bit_idx !== eb || word_idx !== ew || bit_first !== (eb == 4'd1) ||
             bit_pre !== (eb == 4'd3) || bit_last !== (eb == 4'd4) || tile_done !== 1'b0) begin
            failures++;
            $display("FAIL p4_step%0d: bit=%0d word=%0d f/p/l=%b%b%b done=%b, want %0d %0d",
                     i, bit_idx, word_idx, bit_first, bit_pre, bit_last, tile_done, eb, ew);
         end
      end
      tick();
      checks++;
      if (tile_done !== 1'b1 || busy !== 1'b0 || bit_idx !== 4'd0 || bit_last !== 1'b0 ||
          word_idx !== 8'd1) begin
         failures++;
         $display("FAIL p4_done: done=%b busy=%b bit=%0d last=%b word=%0d, want 1 0 0 0 1",
                  tile_done, busy, bit_idx, bit_last, word_idx);
      end
      tick();
      checks++;
      if (cfg_ready !== 1'b1 || tile_done !== 1'b0) begin
         failures++;
         $display("FAIL p4_idle: rdy=%b done=%b, want 1 0", cfg_ready, tile_done);
      end
   endtask

   task automatic test_prec1_gaps();
      do_cfg(4'd1, 9'd3);
      for (int i = 0; i < 3; i++) begin
         w_cnt = 1'b1;
         tick();
         w_cnt = 1'b0;
         checks++;
         if (bit_idx !== 4'd1 || word_idx !== 8'(i) || bit_first !== 1'b1 ||
             bit_last !== 1'b1 || bit_pre !== 1'b0 || tile_done !== 1'b0) begin
            failures++;
            $display("FAIL p1_strobe%0d: bit=%0d word=%0d f/p/l=%b%b%b, want 1 %0d 101",
                     i, bit_idx, word_idx, bit_first, bit_pre, bit_last, i);
         end
         if (i < 2) begin
            for (int g = 0; g < 2; g++) begin
               tick();
               checks++;
               if (bit_idx !== 4'd1 || word_idx !== 8'(i) || busy !== 1'b1 ||
                   tile_done !== 1'b0) begin
                  failures++;
                  $display("FAIL p1_gap%0d_%0d: bit=%0d word=%0d busy=%b, want 1 %0d 1",
                           i, g, bit_idx, word_idx, busy, i);
               end
            end
         end
      end
      tick();
      checks++;
      if (tile_done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL p1_done: done=%b busy=%b, want 1 0", tile_done, busy);
      end
      tick();
   endtask

   task automatic test_illegal();
      logic [3:0] tp [4] = '{4'd0, 4'd9, 4'd4, 4'd4};
      logic [8:0] tn [4] = '{9'd2, 9'd2, 9'd0, 9'd257};
      for (int k = 0; k < 4; k++) begin
         do_cfg(tp[k], tn[k]);
         checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal%0d: err=%b busy=%b rdy=%b, want 1 0 1",
                     k, cfg_err, busy, cfg_ready);
         end
         tick();
         checks++;
         if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal%0d_pulse: err=%b busy=%b, want 0 0", k, cfg_err, busy);
         end
      end
   endtask

   task automatic test_clear();
      do_cfg(4'd8, 9'd4);
      w_cnt = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      checks++;
      if (bit_idx !== 4'd5 || word_idx !== 8'd2) begin
         failures++;
         $display("FAIL clr_pos: bit=%0d word=%0d, want 5 2", bit_idx, word_idx);
      end
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      checks++;
      if (bit_idx !== 4'd0 || word_idx !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
          tile_done !== 1'b0 || {bit_first, bit_pre, bit_last} !== 3'b000) begin
         failures++;
         $display("FAIL clr_next: bit=%0d word=%0d busy=%b rdy=%b done=%b, want 0 0 0 1 0",
                  bit_idx, word_idx, busy, cfg_ready, tile_done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bit_idx !== 4'd0 || busy !== 1'b0 || tile_done !== 1'b0) begin
            failures++;
            $display("FAIL clr_after%0d: bit=%0d busy=%b done=%b, want 0 0 0",
                     i, bit_idx, busy, tile_done);
         end
      end
      w_cnt = 1'b0;
   endtask

   task automatic test_cfg_in_run();
      do_cfg(4'd5, 9'd1);
      w_cnt = 1'b1;
      tick();
      tick();
      cfg_valid = 1'b1;
      cfg_prec  = 4'd3;
      for (int b = 3; b <= 5; b++) begin
         tick();
         checks++;
         if (bit_idx !== 4'(b) || cfg_err !== 1'b0 || bit_pre !== (b == 4) ||
             bit_last !== (b == 5) || busy !== 1'b1) begin
            failures++;
            $display("FAIL run_cfg_b%0d: bit=%0d err=%b pre=%b last=%b busy=%b", b,
                     bit_idx, cfg_err, bit_pre, bit_last, busy);
         end
      end
      cfg_valid = 1'b0;
      w_cnt = 1'b0;
      tick();
      checks++;
      if (tile_done !== 1'b1) begin
         failures++;
         $display("FAIL run_cfg_done: done=%b, want 1", tile_done);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_cfg(4'd4, 9'd2);
      w_cnt = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      w_cnt = 1'b0;
      checks++;
      if (bit_idx !== 4'd2 || word_idx !== 8'd1) begin
         failures++;
         $display("FAIL arst_pre: bit=%0d word=%0d, want 2 1", bit_idx, word_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bit_idx !== 4'd0 || word_idx !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
          bit_first !== 1'b0) begin
         failures++;
         $display("FAIL arst_now: bit=%0d word=%0d busy=%b rdy=%b, want 0 0 0 1",
                  bit_idx, word_idx, busy, cfg_ready);
      end
      #2;
      rst_n = 1'b1;
      w_cnt = 1'b1;
      tick();
      tick();
      w_cnt = 1'b0;
      checks++;
      if (bit_idx !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL arst_after: bit=%0d busy=%b, want 0 0", bit_idx, busy);
      end
   endtask

   initial begin
      cfg_valid  = 1'b0;
      cfg_prec   = '0;
      cfg_nwords = '0;
      w_cnt      = 1'b0;
      cnt_clear  = 1'b0;
      test_reset();
      test_prec4();
      test_prec1_gaps();
      test_illegal();
      test_clear();
      test_cfg_in_run();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
